snake_pattern_decoder: RTL and testbench
========================================

# snake_pattern_decoder

Receiving end of the 4-digit seven-segment snake bus. Samples the active-low `seg`/`an` lines each clock and maps each sample to its position in the 20-step snake pattern. It locks onto the sequence, checks every step against the expected next step, and reports step index, lock status, errors and completed laps. It sits beside the pattern generator as an in-system monitor and self-check for the display path.

## Interface
- `LAP_W`, default 16: width of the lap counter.
- `ERR_W`, default 8: width of the saturating error counter.
- `CLK` in 1: single clock. All state updates on the rising edge.
- `RST` in 1: reset, asynchronous and active-high.
- `seg_in` in 8: segment lines, active low. Bit 7=A(top), 6=B(TR), 5=C(BR), 4=D(bot), 3=E(BL), 2=F(TL), 1=G(mid), 0=DP.
- `an_in` in 4: digit anodes, active low. Bit 0 = digit one.
- `locked` out 1: decoder is synchronised to the pattern.
- `step_idx` out 5: current step, 0–19. Valid while `locked`.
- `step_pulse` out 1: one-cycle pulse on each accepted step advance, including the lock step.
- `err_pulse` out 1: one-cycle pulse on each mismatch detected while locked.
- `err_count` out ERR_W: number of mismatches, saturating.
- `lap_count` out LAP_W: number of 19→0 advances, wraps.
- `frame` out 32: last segment byte seen per digit. `[8d+7:8d]` is digit d.

## Operation
- Step table, as (digit, segment):
  - 0–3: A on d0..d3
  - 4: B on d3
  - 5–8: G on d3..d0
  - 9: E on d0
  - 10–13: D on d0..d3
  - 14: C on d3
  - 15–18: G on d3..d0
  - 19: F on d0
- A sample is valid only when exactly one `an_in` bit is low and exactly one `seg_in` bit is low. DP alone is never a table entry.
- Stage 1 registers the raw `seg_in`/`an_in`. Stage 2 decodes the sample and runs the tracker FSM.
- FSM state HUNT:
  - Ignores invalid samples and G samples, because G steps are ambiguous.
  - A valid non-G sample matching table step s → LOCKED, `step_idx`=s, `step_pulse`=1.
- FSM state LOCKED:
  - Sample equal to the previous stage-1 sample → stall. No advance, no error.
  - Sample matching step (`step_idx`+1) mod 20 → advance and pulse `step_pulse`. If the advance is 19→0, `lap_count`+1.
  - Any other sample, including an invalid one → `err_pulse`, `err_count`+1 (saturating at all-ones), state HUNT, `locked`=0.
- Stall and mismatch are evaluated together. Stall has priority: a repeated invalid sample right after an error stays in HUNT without a second error.
- Reset values:
  - FSM in HUNT.
  - All outputs 0, `frame` = 0xFFFF_FFFF (all segments off).
  - Previous-sample register = 0xFFF.

## Timing
- Latency from pin change to outputs is 2 clocks: stage-1 register, then stage-2 decode/FSM register. All outputs are registered.
- `step_pulse` and `err_pulse` are never high in the same cycle.
- `RST` asserted mid-run clears everything asynchronously. After `RST` falls, the first lock needs one valid non-G sample, which appears at the outputs 2 clocks after it is on the pins.
- Maximum input rate is one step per clock. Back-to-back distinct steps each advance.

## Configuration
- `SNAKE_DEC_FRAME_EN` defined:
  - `frame` is maintained.
  - On each valid sample, the byte of the lit digit is overwritten with `seg_in`. Other bytes hold.
  - Invalid samples do not update `frame`.
- `SNAKE_DEC_FRAME_EN` undefined:
  - The `frame` port remains but is tied to 0xFFFF_FFFF.
  - No frame registers are synthesised.

## Structure
- Package `snake_pkg` holds:
  - `SNAKE_STEPS` = 20.
  - The segment-bit index constants (`SEG_A`..`SEG_DP`).
  - The step lookup constant array: 20 entries of {digit[1:0], seg_bit[2:0]}.
  - The tracker state enum {HUNT, LOCKED}.
- Sub-module `snake_sample_decode` (combinational) takes a registered `seg`/`an` sample and outputs:
  - `valid`
  - `digit`
  - `seg_bit`
  - `is_mid`
  - `match_step` (5 bits; only meaningful for non-G samples)

## Test plan
- Full sequence after reset: drive steps 0..19 then 0, one per clock.
  - `locked`=1 two clocks after step 0 is on the pins, `step_idx`=0.
  - `step_pulse` each cycle.
  - `lap_count`=1 after the 19→0 advance.
  - `err_count`=0.
- Lock on a non-G step: start the sequence at step 5 (G on d3). HUNT ignores steps 5–8, then locks at step 9 with `step_idx`=9.
- Mismatch: while locked at step 3, drive step 10 (D on d0).
  - One `err_pulse`, `err_count`=1, `locked`=0.
  - A subsequent valid step 11 relocks with `step_idx`=11.
- Stall: hold step 12 for 5 clocks, then drive step 13. No error, a single `step_pulse`, `step_idx`=13.
- Invalid samples:
  - `an_in`=4'b1100 while locked → error.
  - 300 such errors leave `err_count`=255 when ERR_W=8.
- Reset and frame:
  - Assert `RST` mid-lap → all outputs reset asynchronously, `frame`=0xFFFF_FFFF.
  - With `SNAKE_DEC_FRAME_EN` defined, after steps 0..3 `frame`=0x7F7F_7F7F.

Source files
------------

// File: rtl/snake_pattern_decoder_pkg.sv
// Shared constants for the seven-segment snake bus: step count, segment bit
// positions, the 20-step lookup table and the tracker state encoding.
package snake_pkg;

    localparam int SNAKE_STEPS = 20;

    localparam logic [4:0] LAST_STEP = 5'd19;
    localparam logic [4:0] NO_MATCH  = 5'h1F;

    localparam logic [2:0] SEG_A  = 3'd7;
    localparam logic [2:0] SEG_B  = 3'd6;
    localparam logic [2:0] SEG_C  = 3'd5;
    localparam logic [2:0] SEG_D  = 3'd4;
    localparam logic [2:0] SEG_E  = 3'd3;
    localparam logic [2:0] SEG_F  = 3'd2;
    localparam logic [2:0] SEG_G  = 3'd1;
    localparam logic [2:0] SEG_DP = 3'd0;

    // Each entry is {digit, seg_bit}
    localparam logic [4:0] SNAKE_TABLE [SNAKE_STEPS] = '{
        {2'd0, SEG_A}, {2'd1, SEG_A}, {2'd2, SEG_A}, {2'd3, SEG_A},
        {2'd3, SEG_B},
        {2'd3, SEG_G}, {2'd2, SEG_G}, {2'd1, SEG_G}, {2'd0, SEG_G},
        {2'd0, SEG_E},
        {2'd0, SEG_D}, {2'd1, SEG_D}, {2'd2, SEG_D}, {2'd3, SEG_D},
        {2'd3, SEG_C},
        {2'd3, SEG_G}, {2'd2, SEG_G}, {2'd1, SEG_G}, {2'd0, SEG_G},
        {2'd0, SEG_F}
    };

    typedef enum logic {
        HUNT,
        LOCKED
    } trk_state_t;

    function automatic logic [4:0] next_step(input logic [4:0] s);
        return (s == LAST_STEP) ? 5'd0 : s + 5'd1;
    endfunction

endpackage

// File: rtl/snake_pattern_decoder_sample_decode.sv
// Combinational decode of one registered seg/an sample into digit, segment
// bit and (for non-G samples) the unique table step it corresponds to.
module snake_sample_decode
    import snake_pkg::*;
(
    input  logic [7:0] seg,
    input  logic [3:0] an,
    output logic       valid,
    output logic [1:0] digit,
    output logic [2:0] seg_bit,
    output logic       is_mid,
    output logic [4:0] match_step
);

    logic [2:0] an_lo;
    logic [3:0] seg_lo;

    always_comb begin
        an_lo  = 3'd0;
        seg_lo = 4'd0;
        digit  = 2'd0;
        seg_bit = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                an_lo = an_lo + 3'd1;
                digit = 2'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (!seg[i]) begin
                seg_lo  = seg_lo + 4'd1;
                seg_bit = 3'(i);
            end
        end
        valid  = (an_lo == 3'd1) && (seg_lo == 4'd1);
        is_mid = (seg_bit == SEG_G);
    end

    // Non-G entries are unique, so at most one step can hit here
    always_comb begin
        match_step = NO_MATCH;
        for (int s = 0; s < SNAKE_STEPS; s++) begin
            if ((SNAKE_TABLE[s][2:0] != SEG_G) && (SNAKE_TABLE[s] == {digit, seg_bit})) begin
                match_step = 5'(s);
            end
        end
    end

endmodule

// File: rtl/snake_pattern_decoder.sv
// Snake-bus receiver: two-stage sample/track pipeline that locks onto the
// 20-step pattern. Define SNAKE_DEC_FRAME_EN to maintain the per-digit frame.
module snake_pattern_decoder
    import snake_pkg::*;
#(
    parameter int LAP_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       seg_in,
    input  logic [3:0]       an_in,
    output logic             locked,
    output logic [4:0]       step_idx,
    output logic             step_pulse,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [LAP_W-1:0] lap_count,
    output logic [31:0]      frame
);

    logic [7:0]  seg_p1;
    logic [3:0]  an_p1;
    logic [11:0] prev_p1;

    logic        vld_p1;
    logic [1:0]  dig_p1;
    logic [2:0]  bit_p1;
    logic        mid_p1;
    logic [4:0]  mstep_p1;

    logic        stall_p1;
    logic        adv_ok_p1;
    logic        hunt_hit_p1;

    trk_state_t  state_q, state_d;
    logic [4:0]  step_d;
    logic        sp_d, ep_d, lap_inc_d;

    // ---- stage 1: raw pin capture plus the sample before it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg_p1  <= 8'hFF;
            an_p1   <= 4'hF;
            prev_p1 <= 12'hFFF;
        end else begin
            seg_p1  <= seg_in;
            an_p1   <= an_in;
            prev_p1 <= {seg_p1, an_p1};
        end
    end

    // ---- stage 2: decode and tracker
    snake_sample_decode u_decode (
        .seg        (seg_p1),
        .an         (an_p1),
        .valid      (vld_p1),
        .digit      (dig_p1),
        .seg_bit    (bit_p1),
        .is_mid     (mid_p1),
        .match_step (mstep_p1)
    );

    assign stall_p1    = ({seg_p1, an_p1} == prev_p1);
    assign adv_ok_p1   = vld_p1 && (SNAKE_TABLE[next_step(step_idx)] == {dig_p1, bit_p1});
    assign hunt_hit_p1 = vld_p1 && !mid_p1 && (mstep_p1 != NO_MATCH);

    always_comb begin
        state_d   = state_q;
        step_d    = step_idx;
        sp_d      = 1'b0;
        ep_d      = 1'b0;
        lap_inc_d = 1'b0;
        case (state_q)
            HUNT: begin
                if (hunt_hit_p1) begin
                    state_d = LOCKED;
                    step_d  = mstep_p1;
                    sp_d    = 1'b1;
                end
            end
            LOCKED: begin
                // A held sample is the generator pausing, not a fault
                if (!stall_p1) begin
                    if (adv_ok_p1) begin
                        step_d    = next_step(step_idx);
                        sp_d      = 1'b1;
                        lap_inc_d = (step_idx == LAST_STEP);
                    end else begin
                        ep_d    = 1'b1;
                        state_d = HUNT;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= HUNT;
            step_idx   <= 5'd0;
            step_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            lap_count  <= '0;
        end else begin
            state_q    <= state_d;
            step_idx   <= step_d;
            step_pulse <= sp_d;
            err_pulse  <= ep_d;
            if (ep_d && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
            if (lap_inc_d) begin
                lap_count <= lap_count + LAP_W'(1);
            end
        end
    end

    assign locked = (state_q == LOCKED);

`ifdef SNAKE_DEC_FRAME_EN
    logic [31:0] frame_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_q <= 32'hFFFF_FFFF;
        end else if (vld_p1) begin
            frame_q[{dig_p1, 3'b000} +: 8] <= seg_p1;
        end
    end

    assign frame = frame_q;
`else
    assign frame = 32'hFFFF_FFFF;
`endif

endmodule

// File: tb/tb_snake_pattern_decoder.sv
// Scoreboard bench for snake_pattern_decoder: a behavioural model queues the
// expected outputs per driven sample; they are compared two clocks later.
module tb_snake_pattern_decoder;

    localparam int LAP_W = 16;
    localparam int ERR_W = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef SNAKE_DEC_FRAME_EN
    localparam logic [31:0] FRAME_AFTER_TOP = 32'h7F7F_7F7F;
`else
    localparam logic [31:0] FRAME_AFTER_TOP = 32'hFFFF_FFFF;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [7:0]       seg_in = 8'hFF;
    logic [3:0]       an_in = 4'hF;
    logic             locked;
    logic [4:0]       step_idx;
    logic             step_pulse;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [LAP_W-1:0] lap_count;
    logic [31:0]      frame;

    snake_pattern_decoder #(.LAP_W(LAP_W), .ERR_W(ERR_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .seg_in     (seg_in),
        .an_in      (an_in),
        .locked     (locked),
        .step_idx   (step_idx),
        .step_pulse (step_pulse),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .lap_count  (lap_count),
        .frame      (frame)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic             lk;
        logic [4:0]       st;
        logic             sp;
        logic             ep;
        logic [ERR_W-1:0] ec;
        logic [LAP_W-1:0] lc;
        logic [31:0]      fr;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_miscmp = 0;

    // Step table written out as (digit, segment bit index; A=7 .. DP=0)
    int tb_dig[20] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, 0, 0, 1, 2, 3, 3, 3, 2, 1, 0, 0};
    int tb_bit[20] = '{7, 7, 7, 7, 6, 1, 1, 1, 1, 3, 4, 4, 4, 4, 5, 1, 1, 1, 1, 2};

    bit          m_lk;
    int          m_st;
    int          m_ec;
    int          m_lc;
    logic [11:0] m_prev;
    logic [31:0] m_fr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lk   = 1'b0;
        m_st   = 0;
        m_ec   = 0;
        m_lc   = 0;
        m_prev = 12'hFFF;
        m_fr   = 32'hFFFF_FFFF;
        sbq.delete();
    endtask

    task automatic model_apply(input logic [7:0] s, input logic [3:0] a, output exp_t e);
        int nd = 0;
        int ns = 0;
        int d = 0;
        int b = 0;
        int nx;
        bit v;
        bit sp = 1'b0;
        bit ep = 1'b0;
        for (int i = 0; i < 4; i++) if (a[i] == 1'b0) begin nd++; d = i; end
        for (int i = 0; i < 8; i++) if (s[i] == 1'b0) begin ns++; b = i; end
        v  = (nd == 1) && (ns == 1);
        nx = (m_st + 1) % 20;
        if (m_lk) begin
            if ({s, a} == m_prev) begin
                sp = 1'b0;
            end else if (v && d == tb_dig[nx] && b == tb_bit[nx]) begin
                sp = 1'b1;
                if (m_st == 19) m_lc++;
                m_st = nx;
            end else begin
                ep = 1'b1;
                if (m_ec < ERR_MAX) m_ec++;
                m_lk = 1'b0;
            end
        end else if (v && b != 1) begin
            for (int k = 0; k < 20; k++) begin
                if (tb_dig[k] == d && tb_bit[k] == b) begin
                    m_lk = 1'b1;
                    m_st = k;
                    sp   = 1'b1;
                end
            end
        end
`ifdef SNAKE_DEC_FRAME_EN
        if (v) m_fr[8*d +: 8] = s;
`endif
        m_prev = {s, a};
        e.lk = m_lk;
        e.st = 5'(m_st);
        e.sp = sp;
        e.ep = ep;
        e.ec = ERR_W'(m_ec);
        e.lc = LAP_W'(m_lc);
        e.fr = m_fr;
    endtask

    task automatic drive_raw(input logic [7:0] s, input logic [3:0] a);
        exp_t e;
        exp_t g;
        seg_in = s;
        an_in  = a;
        model_apply(s, a, e);
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        if (sbq.size() == 2) begin
            g = sbq.pop_front();
            chk("locked", {31'b0, locked}, {31'b0, g.lk});
            if (g.lk) chk("step_idx", {27'b0, step_idx}, {27'b0, g.st});
            chk("step_pulse", {31'b0, step_pulse}, {31'b0, g.sp});
            chk("err_pulse", {31'b0, err_pulse}, {31'b0, g.ep});
            chk("err_count", 32'(err_count), 32'(g.ec));
            chk("lap_count", 32'(lap_count), 32'(g.lc));
            chk("frame", frame, g.fr);
            chk("pulse_excl", {31'b0, step_pulse & err_pulse}, 32'd0);
        end
    endtask

    task automatic drive(input int step);
        logic [7:0] s = 8'hFF;
        logic [3:0] a = 4'hF;
        a[tb_dig[step]] = 1'b0;
        s[tb_bit[step]] = 1'b0;
        drive_raw(s, a);
    endtask

    task automatic do_reset();
        #2;
        RST    = 1'b1;
        seg_in = 8'hFF;
        an_in  = 4'hF;
        #1;
        chk("rst_locked", {31'b0, locked}, 32'd0);
        chk("rst_step_idx", {27'b0, step_idx}, 32'd0);
        chk("rst_pulses", {30'b0, step_pulse, err_pulse}, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_lap_count", 32'(lap_count), 32'd0);
        chk("rst_frame", frame, 32'hFFFF_FFFF);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(posedge CLK);
        #1;
        do_reset();
        drive_raw(8'hFF, 4'hF);
        drive_raw(8'hFF, 4'hF);

        // full lap 0..19, back to 0, then two more steps
        for (int s = 0; s < 20; s++) drive(s);
        drive(0);
        drive(1);
        drive(2);
        chk("lap_after_wrap", 32'(lap_count), 32'd1);
        chk("err_after_lap", 32'(err_count), 32'd0);
        chk("step_after_wrap", {27'b0, step_idx}, 32'd1);

        // async reset in the middle of a lap
        drive(3);
        drive(4);
        do_reset();

        // HUNT skips the G steps and locks on E
        for (int s = 5; s <= 10; s++) drive(s);
        chk("lock_at_9", {31'b0, locked}, 32'd1);
        chk("lock_step_9", {27'b0, step_idx}, 32'd9);
        do_reset();

        // mismatch while locked at 3, then relock on 11
        for (int s = 0; s <= 3; s++) drive(s);
        drive(10);
        drive(11);
        chk("mis_err_pulse", {31'b0, err_pulse}, 32'd1);
        chk("mis_err_count", 32'(err_count), 32'd1);
        chk("mis_unlocked", {31'b0, locked}, 32'd0);
        drive(12);
        chk("relock", {31'b0, locked}, 32'd1);
        chk("relock_step", {27'b0, step_idx}, 32'd11);

        // step 12 held for five clocks, then 13
        for (int i = 0; i < 4; i++) drive(12);
        drive(13);
        drive(14);
        chk("stall_step", {27'b0, step_idx}, 32'd13);
        chk("stall_no_err", 32'(err_count), 32'd1);

        // invalid (two digits lit) while locked, repeated to saturation
        for (int i = 0; i < 300; i++) begin
            drive_raw(8'h7F, 4'b1100);
            drive(0);
        end
        drive(0);
        chk("err_saturated", 32'(err_count), 32'(ERR_MAX));

        // frame contents after the top row
        do_reset();
        for (int s = 0; s <= 3; s++) drive(s);
        drive(3);
        drive(3);
        chk("frame_top_row", frame, FRAME_AFTER_TOP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
